photon_hash_ctrl: RTL and testbench

Absorb-phase sequencer for the PHOTON-Beetle-Hash datapath. It accepts a byte stream, packs it into 4-byte rate blocks and presents each block as the right-hand operand of the 4-lane XOR stage. It also pads the final block, emits the domain-separation constant, and hands off to the permutation engine between blocks. It sits between the message source and the XOR/permutation datapath.

---
 rtl/photon_hash_ctrl.sv | 142 ++++++++++++++
 tb/tb_photon_hash_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_hash_ctrl.sv
// PHOTON-Beetle-Hash absorb sequencer: packs bytes into 4-lane rate blocks, pads, and hands off to the permutation.
// Optional byte-length counter io_dlen is built only when PHOTON_HASH_CTRL_DLEN_EN is defined.
module photon_hash_ctrl #(
    parameter int RATE_BYTES = 4,
    parameter int LEN_W      = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_empty,
    input  logic             io_din_valid,
    output logic             io_din_ready,
    input  logic [7:0]       io_din_data,
    input  logic             io_din_last,
    output logic             io_blk_valid,
    output logic [7:0]       io_blk_0,
    output logic [7:0]       io_blk_1,
    output logic [7:0]       io_blk_2,
    output logic [7:0]       io_blk_3,
    output logic             io_const_valid,
    output logic [7:0]       io_constant,
    output logic             io_perm_start,
    input  logic             io_perm_done,
    output logic             io_busy,
    output logic             io_done,
    output logic [LEN_W-1:0] io_dlen
);
    localparam int IDX_W = $clog2(RATE_BYTES);

    typedef enum logic [2:0] {IDLE, FILL, ABSORB, PERM, DONE} state_t;

    state_t           state, state_next;
    logic [7:0]       lanes [RATE_BYTES];
    logic [IDX_W-1:0] idx;
    logic             final_blk;
    logic             empty_msg;
    logic             perm_first;
    logic [7:0]       constant;
    logic             accept;
    logic             idx_full;

    assign accept   = (state == FILL) && io_din_valid;
    assign idx_full = (idx == IDX_W'(RATE_BYTES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io_start) state_next = io_empty ? ABSORB : FILL;
            FILL:    if (accept && (idx_full || io_din_last)) state_next = ABSORB;
            ABSORB:  state_next = PERM;
            // The done seen on the request cycle belongs to an earlier operation, so only later ones count.
            PERM:    if (!perm_first && io_perm_done) state_next = final_blk ? DONE : FILL;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        io_din_ready   = 1'b0;
        io_blk_valid   = 1'b0;
        io_const_valid = 1'b0;
        io_perm_start  = 1'b0;
        io_done        = 1'b0;
        io_busy        = (state != IDLE);
        case (state)
            FILL:    io_din_ready = 1'b1;
            ABSORB: begin
                io_blk_valid   = !empty_msg;
                io_const_valid = final_blk;
            end
            PERM:    io_perm_start = perm_first;
            DONE:    io_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RATE_BYTES; i++) lanes[i] <= '0;
            idx        <= '0;
            final_blk  <= 1'b0;
            empty_msg  <= 1'b0;
            perm_first <= 1'b0;
            constant   <= '0;
        end else begin
            perm_first <= (state == ABSORB);
            case (state)
                IDLE: if (io_start) begin
                    for (int i = 0; i < RATE_BYTES; i++) lanes[i] <= '0;
                    idx       <= '0;
                    final_blk <= io_empty;
                    empty_msg <= io_empty;
                    constant  <= io_empty ? 8'd1 : 8'd0;
                end
                FILL: if (accept) begin
                    lanes[idx] <= io_din_data;
                    idx        <= idx + IDX_W'(1);
                    if (idx_full) begin
                        final_blk <= io_din_last;
                        constant  <= 8'd1;
                    end else if (io_din_last) begin
                        // Pad: a single 0x01 right after the last byte; remaining lanes are already zero.
                        lanes[idx + IDX_W'(1)] <= 8'h01;
                        final_blk              <= 1'b1;
                        constant               <= 8'd2;
                    end
                end
                PERM: if (state_next == FILL) begin
                    for (int i = 0; i < RATE_BYTES; i++) lanes[i] <= '0;
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign io_blk_0    = lanes[0];
    assign io_blk_1    = lanes[1];
    assign io_blk_2    = lanes[2];
    assign io_blk_3    = lanes[3];
    assign io_constant = constant;

`ifdef PHOTON_HASH_CTRL_DLEN_EN
    logic [LEN_W-1:0] dlen;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         dlen <= '0;
        else if (state == IDLE && io_start) dlen <= '0;
        else if (accept)                   dlen <= dlen + LEN_W'(1);
    end

    assign io_dlen = dlen;
`else
    assign io_dlen = '0;
`endif

endmodule

// File: tb/tb_photon_hash_ctrl.sv
// Scoreboard bench for photon_hash_ctrl: a byte-level message model predicts absorb blocks and completions.
module tb_photon_hash_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_start = 1'b0, io_empty = 1'b0;
    logic        io_din_valid = 1'b0, io_din_last = 1'b0;
    logic [7:0]  io_din_data = '0;
    logic        io_din_ready;
    logic        io_blk_valid, io_const_valid, io_perm_start, io_busy, io_done;
    logic [7:0]  io_blk_0, io_blk_1, io_blk_2, io_blk_3, io_constant;
    logic        io_perm_done;
    logic [63:0] io_dlen;

    photon_hash_ctrl dut (
        .clock(clock), .reset(reset), .io_start(io_start), .io_empty(io_empty),
        .io_din_valid(io_din_valid), .io_din_ready(io_din_ready), .io_din_data(io_din_data),
        .io_din_last(io_din_last), .io_blk_valid(io_blk_valid), .io_blk_0(io_blk_0),
        .io_blk_1(io_blk_1), .io_blk_2(io_blk_2), .io_blk_3(io_blk_3),
        .io_const_valid(io_const_valid), .io_constant(io_constant),
        .io_perm_start(io_perm_start), .io_perm_done(io_perm_done), .io_busy(io_busy),
        .io_done(io_done), .io_dlen(io_dlen)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_done;
        logic [31:0] lanes;
        logic        bv;
        logic        cv;
        logic [7:0]  k;
        logic [63:0] dlen;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  msg[$];
    int          checks = 0, passes = 0, fails = 0;
    int          cyc = 0, last_acc_cyc = 0, last_strobe_cyc = -10, last_ps_cyc = 0, done_cyc = 0;
    int          perm_cnt = 0, done_cnt = 0;
    bit          hold_mode = 1'b0;
    int          countdown = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Reference: split message into 4-byte chunks; short tail gets 0x01 then zeros.
    function automatic void model_push();
        int   n = msg.size();
        int   nb = (n + 3) / 4;
        exp_t e;
        if (n == 0) begin
            e = '{is_done: 0, lanes: 32'h0, bv: 0, cv: 1, k: 8'd1, dlen: 0};
            q.push_back(e);
        end
        for (int b = 0; b < nb; b++) begin
            e = '{is_done: 0, lanes: 32'h0, bv: 1, cv: 0, k: 8'd1, dlen: 0};
            for (int j = 0; j < 4; j++) begin
                int p = b * 4 + j;
                if (p < n)       e.lanes[j*8 +: 8] = msg[p];
                else if (p == n) e.lanes[j*8 +: 8] = 8'h01;
            end
            if (b == nb - 1) begin
                e.cv = 1;
                e.k  = (n % 4 == 0) ? 8'd1 : 8'd2;
            end
            q.push_back(e);
        end
        e = '{is_done: 1, lanes: 32'h0, bv: 0, cv: 0, k: 8'd0, dlen: 0};
`ifdef PHOTON_HASH_CTRL_DLEN_EN
        e.dlen = 64'(n);
`endif
        q.push_back(e);
    endfunction

    // Permutation engine: random latency, stray done pulses, or done held high in hold_mode.
    initial begin
        io_perm_done = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (hold_mode) io_perm_done = 1'b1;
            else if (countdown > 0) begin
                countdown--;
                io_perm_done = (countdown == 0);
            end else io_perm_done = ($urandom_range(0, 7) == 0);
            if (io_perm_start && !hold_mode) countdown = $urandom_range(1, 4);
        end
    end

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (io_blk_valid || io_const_valid) begin
                chk("ready_in_absorb", io_din_ready, 0);
                if (q.size() == 0) flag("unexpected_block");
                else begin
                    e = q.pop_front();
                    if (e.is_done) flag("block_instead_of_done");
                    else begin
                        chk("lanes", {io_blk_3, io_blk_2, io_blk_1, io_blk_0}, e.lanes);
                        chk("blk_valid", io_blk_valid, e.bv);
                        chk("const_valid", io_const_valid, e.cv);
                        chk("constant", io_constant, e.k);
                        chk("absorb_latency", cyc, last_acc_cyc);
                    end
                end
                last_strobe_cyc = cyc;
            end
            if (io_perm_start) begin
                chk("perm_start_latency", cyc, last_strobe_cyc + 1);
                chk("ready_in_perm", io_din_ready, 0);
                perm_cnt++;
                last_ps_cyc = cyc;
            end
            if (io_done) begin
                chk("ready_in_done", io_din_ready, 0);
                if (q.size() == 0) flag("unexpected_done");
                else begin
                    e = q.pop_front();
                    if (!e.is_done) flag("done_before_block");
                    else chk("dlen", io_dlen, e.dlen);
                end
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic drive(input int nsend);
        int n = msg.size();
        io_empty = (n == 0);
        io_start = 1'b1;
        @(posedge clock); #1;
        io_start = 1'b0;
        io_empty = 1'b0;
        last_acc_cyc = cyc;
        chk("busy_after_start", io_busy, 1);
        for (int i = 0; i < nsend; i++) begin
            int t = 0;
            repeat ($urandom_range(0, 2)) begin
                io_din_valid = 1'b0;
                io_din_last  = 1'($urandom_range(0, 1));
                io_din_data  = 8'($urandom);
                io_start     = 1'($urandom_range(0, 1));
                io_empty     = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
            end
            io_start     = 1'b0;
            io_empty     = 1'b0;
            io_din_valid = 1'b1;
            io_din_data  = msg[i];
            io_din_last  = (i == n - 1);
            while (!io_din_ready && t < 200) begin
                @(posedge clock); #1;
                t++;
            end
            if (!io_din_ready) flag("ready_timeout");
            @(posedge clock); #1;
            last_acc_cyc = cyc;
            io_din_valid = 1'b0;
            io_din_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        if (done_cnt == d0) flag("done_timeout");
        else chk("busy_after_done", io_busy, 0);
    endtask

    task automatic run_msg();
        int d0 = done_cnt;
        int p0 = perm_cnt;
        model_push();
        drive(msg.size());
        wait_done(d0);
        chk("perm_count", perm_cnt - p0, (msg.size() == 0) ? 1 : (msg.size() + 3) / 4);
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_strobes"}, {io_blk_valid, io_const_valid, io_perm_start, io_done}, 0);
        chk({tag, "_ready_busy"}, {io_din_ready, io_busy}, 0);
        chk({tag, "_lanes"}, {io_blk_3, io_blk_2, io_blk_1, io_blk_0}, 0);
        chk({tag, "_constant"}, io_constant, 0);
        chk({tag, "_dlen"}, io_dlen, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        // Idle: din_valid and stray perm_done must not start anything.
        io_din_valid = 1'b1;
        io_din_last  = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        io_din_valid = 1'b0;
        io_din_last  = 1'b0;
        chk("idle_busy", io_busy, 0);
        chk("idle_done_count", done_cnt, 0);

        msg = '{8'h11, 8'h22, 8'h33, 8'h44};                       run_msg();
        msg = '{8'hAA, 8'hBB};                                     run_msg();
        msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};         run_msg();
        msg = '{};                                                 run_msg();
        msg = '{8'h5A};                                            run_msg();
        msg = '{8'h10, 8'h20, 8'h30};                              run_msg();

        // perm_done held high from before PERM entry: accepted only on the second PERM cycle.
        hold_mode = 1'b1;
        msg = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_msg();
        chk("held_done_timing", done_cyc, last_ps_cyc + 2);
        hold_mode = 1'b0;
        @(posedge clock); #1;

        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(0, 13);
            msg = '{};
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            run_msg();
        end

        // Reset while in PERM of the first block of an 8-byte message.
        begin
            int p0 = perm_cnt;
            int d0;
            int t = 0;
            msg = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
            model_push();
            drive(4);
            while (perm_cnt == p0 && t < 50) begin
                @(negedge clock);
                t++;
            end
            if (perm_cnt == p0) flag("perm_timeout");
            #1 reset = 1'b1;
            #1;
            chk_all_zero("abort");
            q.delete();
            d0 = done_cnt;
            @(posedge clock); #1;
            reset = 1'b0;
            repeat (20) @(posedge clock);
            #1;
            chk("abort_no_done", done_cnt, d0);
            chk("abort_idle", io_busy, 0);
        end

        msg = '{8'h77, 8'h88, 8'h99, 8'hAB, 8'hCD};
        run_msg();

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
